dice_display: RTL and testbench
===============================

# dice_display

Display stage downstream of `muxtd`. It consumes the 3-bit `result` together with the `sel` and `button` signals that drive the mux. In traffic mode (`sel`=1) it passes the RAG code to the lamp outputs. In dice mode (`sel`=0) it captures each settled roll on button release, keeps a short roll history, and drives a 4-digit time-multiplexed 7-segment display plus a saturating roll counter.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit stays enabled; legal range ≥ 1.
- `clk`  in  1  rising-edge system clock, shared with `muxtd`.
- `rst`  in  1  reset: rst, synchronous, active-high.
- `sel`  in  1  mode: 1 = traffic, 0 = dice; same net as the `muxtd` `sel`.
- `button`  in  1  roll button; same net as the `muxtd` `button`. The dice advances while high.
- `result`  in  3  `muxtd` output.
- `seg`  out  7  segment drive, active-high; bit6 = g … bit0 = a.
- `an`  out  4  digit enable, one-hot, active-high; bit0 = digit 0.
- `led`  out  3  lamp drive {R,A,G}; zero in dice mode.
- `roll_count`  out  8  number of captured rolls, saturating.

## Operation
- Input registers: `sel_q`, `button_q`, `button_qq` and `result_q` are all sampled every cycle.
- Roll capture:
  - Fires when `sel_q`=0, `button_qq`=1, `button_q`=0 and `result_q` ∈ {1..6}.
  - On capture: `h2`←`h1`, `h1`←`h0`, `h0`←`result_q`, and `roll_count`←min(`roll_count`+1, 255).
  - A release with `result_q` ∈ {0,7} is ignored entirely: no shift and no count.
- History slots hold 0 to mean empty; the reset value of every slot is 0.
- Digit content in dice mode:
  - digit 0 = live `result_q`.
  - digit 1 = `h0`, digit 2 = `h1`, digit 3 = `h2`.
  - A value of 0 or 7 displays blank (`seg`=0).
- Digit content in traffic mode: all digits blank. `led`←`result_q`.
- History is frozen in traffic mode and is not cleared by a change of `sel`. Only `rst` clears it.
- Segment encoding (g..a):
  - 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101
- Scan:
  - `div_cnt` counts 0..`SCAN_DIV`-1.
  - On wrap, `digit_idx` advances 0→1→2→3→0.
  - `an` = one-hot of `digit_idx`.
  - The scan runs in both modes.

## Timing
- Reset values: `seg`=0, `an`=4'b0001, `led`=0, `roll_count`=0, history empty, `div_cnt`=0, `digit_idx`=0.
- `rst` takes priority over all events in the same cycle, including a coincident capture.
- `seg`, `an` and `led` are registered.
- Latency from input to output is 2 cycles: input register, then output register.
- A `result` change reaches `seg` 2 cycles later, provided digit 0 is selected.
- Capture occurs 2 cycles after the `button` falling edge; `h0` and `roll_count` update on that edge.
- The captured value is `result` sampled on the first low `button` cycle. `muxtd` holds its value while the button is low, so this value is stable.
- A mode change to traffic that lands in the same cycle as a release blocks the capture, because the decision uses `sel_q`.
- `an` changes exactly every `SCAN_DIV` cycles. With `SCAN_DIV`=1, the digit changes every cycle.
- Between a digit change and its new `seg` value there is no gap, because both are registered on the same edge.

## Configuration
- `DICE_HISTORY_EN` defined: 3-slot history as above.
- `DICE_HISTORY_EN` undefined:
  - Only `h0` is kept; digits 2–3 are always blank.
  - Digit 1 shows the last roll.
  - `roll_count` still counts every capture.

## Structure
- Shared package `dice_pkg`:
  - 7-bit segment constants `SEG_BLANK`, `SEG_1` … `SEG_6`.
  - `typedef` `rag_t` for the 3-bit lamp code.
  - Localparam `NUM_DIGITS`=4.
- One sub-module: `seg7_decode` (combinational, 3-bit value → 7-bit segments, blank for 0/7). It is instantiated once, on the muxed digit value.

## Test plan
- Reset:
  - Hold `rst` for 3 cycles → `seg`=0, `an`=0001, `led`=0, `roll_count`=0.
  - Release → `an` goes 0001→0010 after 4 cycles with `SCAN_DIV`=4.
- Traffic passthrough:
  - `sel`=1, `result` steps 100→110→001→010 → `led` follows with 2-cycle lag.
  - Every `seg` sample is 0.
  - `roll_count` stays 0.
- Single roll:
  - `sel`=0, `button` high for 5 cycles, then low with `result` held at 3.
  - Two cycles later: `roll_count`=1 and `h0`=3.
  - When `an`=0010, `seg`=1001111.
- History shift (`DICE_HISTORY_EN`):
  - Rolls settle on 2, 5, 6 → digit1=6, digit2=5, digit3=2.
  - A fourth roll of 1 → digits 1..3 = 1, 6, 5.
- Invalid release: release `button` while `result`=0 → no history change and `roll_count` unchanged.
- Saturation and mode switch:
  - 260 valid rolls → `roll_count`=255.
  - Switch to `sel`=1 and back → history is retained.
  - Assert `rst` in the same cycle as a capture → all state is 0.

Source files
------------

// File: rtl/dice_pkg.sv
// Shared constants and types for the dice display stage.
package dice_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    typedef logic [2:0] rag_t;

    // Segment patterns, bit6 = g ... bit0 = a, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;

endpackage

// File: rtl/seg7_decode.sv
// Dice face value to 7-segment pattern; 0 and 7 are not faces and show blank.
module seg7_decode
    import dice_pkg::*;
(
    input  logic [2:0] val,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (val)
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/dice_display.sv
// Display stage behind muxtd: lamp passthrough in traffic mode, roll capture,
// history and scanned 7-segment display in dice mode. DICE_HISTORY_EN keeps 3 rolls.
module dice_display
    import dice_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       button,
    input  logic [2:0] result,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] led,
    output logic [7:0] roll_count
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic                  sel_q, button_q, button_qq;
    rag_t                  result_q;
    logic [2:0]            h0_q, h0_d;
`ifdef DICE_HISTORY_EN
    logic [2:0]            h1_q, h1_d, h2_q, h2_d;
`endif
    logic [7:0]            roll_count_q, roll_count_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [DIGIT_W-1:0]    digit_idx_q, digit_idx_d;
    logic [6:0]            seg_q, seg_d, dec_seg;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    rag_t                  led_q, led_d;
    logic                  capture;
    logic [2:0]            digit_val;

    seg7_decode u_dec (
        .val (digit_val),
        .seg (dec_seg)
    );

    always_comb begin
        // Release edge seen on the registered button; faces 0/7 are not rolls
        capture = !sel_q && button_qq && !button_q
                  && (result_q != 3'd0) && (result_q != 3'd7);

        h0_d         = h0_q;
`ifdef DICE_HISTORY_EN
        h1_d         = h1_q;
        h2_d         = h2_q;
`endif
        roll_count_d = roll_count_q;
        if (capture) begin
`ifdef DICE_HISTORY_EN
            h2_d = h1_q;
            h1_d = h0_q;
`endif
            h0_d = result_q;
            if (roll_count_q != 8'hFF) roll_count_d = roll_count_q + 8'd1;
        end

        div_cnt_d   = div_cnt_q + DIV_W'(1);
        digit_idx_d = digit_idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d   = '0;
            digit_idx_d = digit_idx_q + DIGIT_W'(1);
        end

        // Content is chosen for the digit being enabled on this same edge
        digit_val = 3'd0;
        case (digit_idx_d)
            2'd0:    digit_val = result_q;
            2'd1:    digit_val = h0_q;
`ifdef DICE_HISTORY_EN
            2'd2:    digit_val = h1_q;
            2'd3:    digit_val = h2_q;
`endif
            default: digit_val = 3'd0;
        endcase

        seg_d = sel_q ? SEG_BLANK : dec_seg;
        an_d  = NUM_DIGITS'(1) << digit_idx_d;
        led_d = sel_q ? result_q : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= 1'b0;
            button_q     <= 1'b0;
            button_qq    <= 1'b0;
            result_q     <= 3'd0;
            h0_q         <= 3'd0;
`ifdef DICE_HISTORY_EN
            h1_q         <= 3'd0;
            h2_q         <= 3'd0;
`endif
            roll_count_q <= 8'd0;
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= NUM_DIGITS'(1);
            led_q        <= 3'd0;
        end else begin
            sel_q        <= sel;
            button_q     <= button;
            button_qq    <= button_q;
            result_q     <= result;
            h0_q         <= h0_d;
`ifdef DICE_HISTORY_EN
            h1_q         <= h1_d;
            h2_q         <= h2_d;
`endif
            roll_count_q <= roll_count_d;
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            led_q        <= led_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign led        = led_q;
    assign roll_count = roll_count_q;

endmodule

// File: tb/tb_dice_display.sv
// Randomized and directed bench for dice_display against a cycle-level behavioural model.
module tb_dice_display;

    localparam int SD = 4;
`ifdef DICE_HISTORY_EN
    localparam bit HIST = 1'b1;
`else
    localparam bit HIST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       button = 1'b0;
    logic [2:0] result = 3'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] led;
    logic [7:0] roll_count;

    dice_display #(.SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .button     (button),
        .result     (result),
        .seg        (seg),
        .an         (an),
        .led        (led),
        .roll_count (roll_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: roll history (newest first), roll count, edges since reset,
    // and the inputs as seen at the previous one/two edges.
    int m_hist[3];
    int m_cnt, m_n, m_d, m_v;
    int p1_sel, p1_btn, p1_res, p2_btn;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic [2:0] e_led;

    function automatic logic [6:0] segtab(input int v);
        case (v)
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            if (rst) begin
                m_hist[0] = 0; m_hist[1] = 0; m_hist[2] = 0;
                m_cnt = 0; m_n = 0;
                p1_sel = 0; p1_btn = 0; p1_res = 0; p2_btn = 0;
                e_seg = 7'd0; e_an = 4'b0001; e_led = 3'd0;
            end else begin
                m_n++;
                m_d = (m_n / SD) % 4;
                case (m_d)
                    0: m_v = p1_res;
                    1: m_v = m_hist[0];
                    2: m_v = HIST ? m_hist[1] : 0;
                    default: m_v = HIST ? m_hist[2] : 0;
                endcase
                e_seg = (p1_sel != 0) ? 7'd0 : segtab(m_v);
                e_an  = 4'(1 << m_d);
                e_led = (p1_sel != 0) ? 3'(p1_res) : 3'd0;
                if (p1_sel == 0 && p2_btn == 1 && p1_btn == 0 && p1_res >= 1 && p1_res <= 6) begin
                    m_hist[2] = m_hist[1];
                    m_hist[1] = m_hist[0];
                    m_hist[0] = p1_res;
                    if (m_cnt < 255) m_cnt++;
                end
                p2_btn = p1_btn;
                p1_sel = int'(sel);
                p1_btn = int'(button);
                p1_res = int'(result);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("seg", 32'(seg), 32'(e_seg));
                check("an", 32'(an), 32'(e_an));
                check("led", 32'(led), 32'(e_led));
                check("roll_count", 32'(roll_count), 32'(m_cnt));
            end
        end
    end

    task automatic step(input bit s, input bit b, input logic [2:0] r);
        @(negedge clk);
        #1;
        sel = s; button = b; result = r;
    endtask

    // Press for hi cycles with a rolling face, release on v, hold until captured
    task automatic roll(input int v, input int hi);
        for (int i = 0; i < hi; i++) step(1'b0, 1'b1, 3'($urandom_range(1, 6)));
        step(1'b0, 1'b0, 3'(v));
        step(1'b0, 1'b0, 3'(v));
        step(1'b0, 1'b0, 3'(v));
    endtask

    task automatic check_digit(input int idx, input int v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an == 4'(1 << idx)) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) check($sformatf("digit%0d", idx), 32'(seg), 32'(segtab(v)));
        else begin
            vectors++;
            miscompares++;
            $display("FAIL digit%0d select: an stuck at %b", idx, an);
        end
    endtask

    int rv;
    int lastv[3];

    initial begin : stim
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_an", 32'(an), 32'b0001);
        check("rst_led", 32'(led), 32'd0);
        check("rst_cnt", 32'(roll_count), 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("scan_hold", 32'(an), 32'b0001);
        @(negedge clk);
        check("scan_step", 32'(an), 32'b0010);

        // Traffic passthrough
        foreach (lastv[i]) lastv[i] = 0;
        begin
            logic [2:0] tv [4];
            tv[0] = 3'b100; tv[1] = 3'b110; tv[2] = 3'b001; tv[3] = 3'b010;
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 1'b0, tv[i]);
                repeat (2) @(negedge clk);
                check("traffic_led", 32'(led), 32'(tv[i]));
                check("traffic_seg", 32'(seg), 32'd0);
            end
        end
        check("traffic_cnt", 32'(roll_count), 32'd0);
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);

        // Single roll
        roll(3, 5);
        @(negedge clk);
        check("single_cnt", 32'(roll_count), 32'd1);
        check_digit(1, 3);

        // History shift
        roll(2, 3); roll(5, 4); roll(6, 2);
        check_digit(1, 6); check_digit(2, HIST ? 5 : 0); check_digit(3, HIST ? 2 : 0);
        roll(1, 3);
        check_digit(1, 1); check_digit(2, HIST ? 6 : 0); check_digit(3, HIST ? 5 : 0);
        check("hist_cnt", 32'(roll_count), 32'd5);

        // Invalid releases
        roll(0, 3);
        roll(7, 2);
        @(negedge clk);
        check("invalid_cnt", 32'(roll_count), 32'd5);
        check_digit(1, 1); check_digit(2, HIST ? 6 : 0);

        // Saturation
        for (int i = 0; i < 260; i++) begin
            rv = int'($urandom_range(1, 6));
            roll(rv, 1);
            lastv[2] = lastv[1]; lastv[1] = lastv[0]; lastv[0] = rv;
        end
        @(negedge clk);
        check("sat_cnt", 32'(roll_count), 32'd255);

        // Traffic excursion with button activity, then back to dice
        for (int i = 0; i < 12; i++) step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        step(1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd3);
        check_digit(1, lastv[0]);
        check_digit(2, HIST ? lastv[1] : 0);
        check_digit(3, HIST ? lastv[2] : 0);
        check("mode_cnt", 32'(roll_count), 32'd255);

        // Random traffic against the model, with occasional resets
        begin
            bit b;
            b = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 9) < 3) b = ~b;
                @(negedge clk);
                #1;
                rst    = ($urandom_range(0, 63) == 0);
                sel    = ($urandom_range(0, 3) == 0);
                button = b;
                result = 3'($urandom_range(0, 7));
            end
        end
        step(1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 3'd0);

        // Reset coincident with a capture
        roll(4, 2);
        step(1'b0, 1'b1, 3'd5);
        step(1'b0, 1'b1, 3'd5);
        step(1'b0, 1'b0, 3'd5);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstcap_cnt", 32'(roll_count), 32'd0);
        check("rstcap_seg", 32'(seg), 32'd0);
        check("rstcap_an", 32'(an), 32'b0001);
        check("rstcap_led", 32'(led), 32'd0);
        #1 rst = 1'b0;
        result = 3'd0;
        check_digit(0, 0); check_digit(1, 0); check_digit(2, 0); check_digit(3, 0);
        check("rstcap_cnt2", 32'(roll_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        miscompares++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
